// File: rtl/fsb_cycle_responder_if.sv
// rtl/fsb_cycle_responder_if.sv - FSB cycle-termination bus between decoder/CPU side and responder
interface fsb_cycle_responder_if;
    logic nAS;
    logic RAMCS;
    logic ROMCS;
    logic IOCS;
    logic IACS;
    logic RAMReady;
    logic IOACK;
    logic nDTACK;
    logic nVPA;
    logic nBERR;
    logic IOREQ;

    modport master (
        output nAS, RAMCS, ROMCS, IOCS, IACS, RAMReady, IOACK,
        input  nDTACK, nVPA, nBERR, IOREQ
    );

    modport slave (
        input  nAS, RAMCS, ROMCS, IOCS, IACS, RAMReady, IOACK,
        output nDTACK, nVPA, nBERR, IOREQ
    );
endinterface

// File: rtl/fsb_cycle_responder.sv
// rtl/fsb_cycle_responder.sv - MC68HC000 FSB cycle terminator (DTACK/VPA/BERR) with IOB request handshake
module fsb_cycle_responder #(
    parameter int ROM_WS  = 2,
    parameter int TO_BITS = 8
) (
    input logic                  CLK,
    input logic                  RES,
    fsb_cycle_responder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_IACK, S_RAMW, S_ROMW, S_IOW, S_TERM, S_BERR
    } state_t;

    localparam logic [TO_BITS-1:0] TO_MAX  = '1;
    localparam logic [3:0]         WS_INIT = 4'(ROM_WS);

    state_t             state_q, state_d;
    logic [3:0]         ws_cnt_q, ws_cnt_d;
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic               ramdone_q, ramdone_d;
    logic               iodone_q, iodone_d;
    logic               iopend_q, iopend_d;
    logic               want_q, want_d;
    logic               ackd_q, ackd_d;
    logic               ioreq_q, ioreq_d;
    logic               ndtack_q, ndtack_d;
    logic               nvpa_q, nvpa_d;
    logic               nberr_q, nberr_d;
    logic               new_req, cycle_exit, to_fire, io_ack_ours, want_set, raise;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q   <= S_IDLE;
            ws_cnt_q  <= '0;
            to_cnt_q  <= '0;
            ramdone_q <= 1'b0;
            iodone_q  <= 1'b0;
            iopend_q  <= 1'b0;
            want_q    <= 1'b0;
            ackd_q    <= 1'b0;
            ioreq_q   <= 1'b0;
            ndtack_q  <= 1'b1;
            nvpa_q    <= 1'b1;
            nberr_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            ws_cnt_q  <= ws_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ramdone_q <= ramdone_d;
            iodone_q  <= iodone_d;
            iopend_q  <= iopend_d;
            want_q    <= want_d;
            ackd_q    <= ackd_d;
            ioreq_q   <= ioreq_d;
            ndtack_q  <= ndtack_d;
            nvpa_q    <= nvpa_d;
            nberr_q   <= nberr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ws_cnt_d    = ws_cnt_q;
        to_cnt_d    = to_cnt_q;
        ramdone_d   = ramdone_q;
        iodone_d    = iodone_q;
        iopend_d    = iopend_q;
        ndtack_d    = ndtack_q;
        nvpa_d      = nvpa_q;
        nberr_d     = nberr_q;
        new_req     = 1'b0;
        cycle_exit  = 1'b0;
        to_cnt_inc  = to_cnt_q + 1'b1;
        to_fire     = (to_cnt_inc == TO_MAX);
        // An ack only counts for this cycle once our own request is on the wire.
        io_ack_ours = iopend_q && !want_q && ioreq_q && bus.IOACK;
        ackd_d      = ioreq_q && bus.IOACK;

        case (state_q)
            S_IDLE: begin
                if (!bus.nAS) begin
                    to_cnt_d = '0;
                    if (bus.IACS) begin
                        state_d = S_IACK;
                    end else if (bus.RAMCS) begin
                        state_d  = S_RAMW;
                        iopend_d = bus.IOCS;
                        new_req  = bus.IOCS;
                    end else if (bus.ROMCS) begin
                        state_d  = S_ROMW;
                        ws_cnt_d = WS_INIT;
                    end else begin
                        state_d  = S_IOW;
                        iopend_d = bus.IOCS;
                        new_req  = bus.IOCS;
                    end
                end
            end
            S_IACK: begin
                to_cnt_d = to_cnt_inc;
                nvpa_d   = 1'b0;
                state_d  = S_TERM;
            end
            S_RAMW: begin
                to_cnt_d  = to_cnt_inc;
                ramdone_d = ramdone_q | bus.RAMReady;
                iodone_d  = iodone_q | io_ack_ours;
                if (bus.nAS) begin
                    state_d    = S_IDLE;
                    cycle_exit = 1'b1;
                end else if (ramdone_q && (iodone_q || !iopend_q)) begin
                    ndtack_d   = 1'b0;
                    state_d    = S_TERM;
                    cycle_exit = 1'b1;
                end else if (to_fire) begin
                    nberr_d    = 1'b0;
                    state_d    = S_BERR;
                    cycle_exit = 1'b1;
                end
            end
            S_ROMW: begin
                to_cnt_d = to_cnt_inc;
                ws_cnt_d = ws_cnt_q - 4'd1;
                if (bus.nAS) begin
                    state_d    = S_IDLE;
                    cycle_exit = 1'b1;
                end else if (ws_cnt_q == 4'd0) begin
                    ndtack_d   = 1'b0;
                    state_d    = S_TERM;
                    cycle_exit = 1'b1;
                end else if (to_fire) begin
                    nberr_d    = 1'b0;
                    state_d    = S_BERR;
                    cycle_exit = 1'b1;
                end
            end
            S_IOW: begin
                to_cnt_d = to_cnt_inc;
                if (bus.nAS) begin
                    state_d    = S_IDLE;
                    cycle_exit = 1'b1;
                end else if (io_ack_ours) begin
                    ndtack_d   = 1'b0;
                    state_d    = S_TERM;
                    cycle_exit = 1'b1;
                end else if (to_fire) begin
                    nberr_d    = 1'b0;
                    state_d    = S_BERR;
                    cycle_exit = 1'b1;
                end
            end
            S_TERM: begin
                if (bus.nAS) begin
                    ndtack_d = 1'b1;
                    nvpa_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_BERR: begin
                if (bus.nAS) begin
                    nberr_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cycle_exit) begin
            ramdone_d = 1'b0;
            iodone_d  = 1'b0;
            iopend_d  = 1'b0;
        end

        // Handshake runs on its own: a raised IOREQ always completes, even after abort.
        want_set = (want_q && !cycle_exit) || new_req;
        raise    = !ioreq_q && want_set && !bus.IOACK;
        ioreq_d  = raise || (ioreq_q && !ackd_q);
        want_d   = want_set && !raise;
    end

    assign bus.nDTACK = ndtack_q;
    assign bus.nVPA   = nvpa_q;
    assign bus.nBERR  = nberr_q;
    assign bus.IOREQ  = ioreq_q;
endmodule
